// File: rtl/cacheline_burst_adaptor.sv
// Cache-line to memory-burst adaptor.
// A 256-bit line request from the cache side becomes a NUM_BEATS-beat burst
// on the memory bus. Read beats are gathered into a full line. Write lines
// are sliced into beats, one beat per accepted memory strobe.
module cacheline_burst_adaptor #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int NUM_BEATS   = LINE_WIDTH / BURST_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  input  logic [31:0]            address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  output logic                   resp_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  output logic [BURST_WIDTH-1:0] burst_o,
  output logic [31:0]            address_o,
  output logic                   read_o,
  output logic                   write_o,
  input  logic                   resp_i
);

  localparam int CNT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t                state, next_state;
  logic [CNT_W-1:0]      cnt;
  logic [31:0]           addr_q;
  logic [LINE_WIDTH-1:0] wline_q;
  logic [LINE_WIDTH-1:0] rbuf;
  logic [LINE_WIDTH-1:0] asm_line;
  logic [LINE_WIDTH-1:0] line_q;

  // State register; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode: read wins over write, the last strobed beat exits.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (read_i) begin
          next_state = RD_BURST;
        end else if (write_i) begin
          next_state = WR_BURST;
        end
      end
      RD_BURST: begin
        if (resp_i && (cnt == LAST_BEAT)) begin
          next_state = DONE;
        end
      end
      WR_BURST: begin
        if (resp_i && (cnt == LAST_BEAT)) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Read buffer with the current beat merged into slot cnt.
  always_comb begin
    asm_line = rbuf;
    for (int i = 0; i < NUM_BEATS; i++) begin
      if (cnt == CNT_W'(i)) begin
        asm_line[i*BURST_WIDTH +: BURST_WIDTH] = burst_i;
      end
    end
  end

  // Request latching, beat counting and read-line assembly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      rbuf    <= '0;
      line_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (read_i) begin
            addr_q <= address_i & 32'hFFFF_FFE0;
            cnt    <= '0;
          end else if (write_i) begin
            addr_q  <= address_i & 32'hFFFF_FFE0;
            wline_q <= line_i;
            cnt     <= '0;
          end
        end
        RD_BURST: begin
          if (resp_i) begin
            rbuf <= asm_line;
            cnt  <= cnt + 1'b1;
            // The line becomes visible to the cache only once complete.
            if (cnt == LAST_BEAT) begin
              line_q <= asm_line;
            end
          end
        end
        WR_BURST: begin
          if (resp_i) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs decode straight from state so reset clears them immediately.
  always_comb begin
    read_o    = (state == RD_BURST);
    write_o   = (state == WR_BURST);
    resp_o    = (state == DONE);
    address_o = addr_q;
    line_o    = line_q;
    burst_o   = '0;
    if (state == WR_BURST) begin
      for (int i = 0; i < NUM_BEATS; i++) begin
        if (cnt == CNT_W'(i)) begin
          burst_o = wline_q[i*BURST_WIDTH +: BURST_WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Bench for cacheline_burst_adaptor: directed scenarios plus randomized
// line transactions, all outputs compared each cycle against a
// transaction-level reference model.
module tb_cacheline_burst_adaptor;

  localparam int LW = 256;
  localparam int BW = 64;
  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [LW-1:0] line_i = '0;
  logic [LW-1:0] line_o;
  logic [31:0]   address_i = '0;
  logic          read_i = 1'b0;
  logic          write_i = 1'b0;
  logic          resp_o;
  logic [BW-1:0] burst_i = '0;
  logic [BW-1:0] burst_o;
  logic [31:0]   address_o;
  logic          read_o;
  logic          write_o;
  logic          resp_i = 1'b0;

  int errors = 0;
  int checks = 0;

  cacheline_burst_adaptor #(
    .LINE_WIDTH (LW),
    .BURST_WIDTH(BW),
    .NUM_BEATS  (NB)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .line_i   (line_i),
    .line_o   (line_o),
    .address_i(address_i),
    .read_i   (read_i),
    .write_i  (write_i),
    .resp_o   (resp_o),
    .burst_i  (burst_i),
    .burst_o  (burst_o),
    .address_o(address_o),
    .read_o   (read_o),
    .write_o  (write_o),
    .resp_i   (resp_i)
  );

  always #5 clk = ~clk;

  task automatic chk_w(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Transaction view: which line transfer is in progress, how many beats
  // have been exchanged, and the lines/addresses the cache should see.
  typedef enum int {M_IDLE, M_READ, M_WRITE, M_RESP} mmode_t;
  mmode_t        m_mode = M_IDLE;
  int            m_k = 0;
  logic [31:0]   m_addr = '0;
  logic [LW-1:0] m_wline = '0;
  logic [LW-1:0] m_line = '0;
  logic [BW-1:0] m_beats [NB];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_mode  <= M_IDLE;
      m_k     <= 0;
      m_addr  <= '0;
      m_wline <= '0;
      m_line  <= '0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (read_i) begin
            m_addr <= {address_i[31:5], 5'b00000};
            m_k    <= 0;
            m_mode <= M_READ;
          end else if (write_i) begin
            m_addr  <= {address_i[31:5], 5'b00000};
            m_wline <= line_i;
            m_k     <= 0;
            m_mode  <= M_WRITE;
          end
        end
        M_READ: begin
          if (resp_i) begin
            m_beats[m_k] <= burst_i;
            m_k <= m_k + 1;
            if (m_k == NB - 1) begin
              for (int j = 0; j < NB; j++) begin
                m_line[j*BW +: BW] <= (j == m_k) ? burst_i : m_beats[j];
              end
              m_mode <= M_RESP;
            end
          end
        end
        M_WRITE: begin
          if (resp_i) begin
            m_k <= m_k + 1;
            if (m_k == NB - 1) m_mode <= M_RESP;
          end
        end
        default: m_mode <= M_IDLE;
      endcase
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [BW-1:0] eb;
    eb = (m_mode == M_WRITE) ? m_wline[m_k*BW +: BW] : '0;
    chk_b("read_o", read_o, m_mode == M_READ);
    chk_b("write_o", write_o, m_mode == M_WRITE);
    chk_b("resp_o", resp_o, m_mode == M_RESP);
    chk_w("address_o", LW'(address_o), LW'(m_addr));
    chk_w("burst_o", LW'(burst_o), LW'(eb));
    chk_w("line_o", line_o, m_line);
  end

  // ---------------- stimulus helpers ----------------
  // Mid-cycle asynchronous reset; outputs must clear without a clock edge.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    chk_b("rst_read_o", read_o, 1'b0);
    chk_b("rst_write_o", write_o, 1'b0);
    chk_b("rst_resp_o", resp_o, 1'b0);
    chk_w("rst_line_o", line_o, '0);
    chk_w("rst_address_o", LW'(address_o), '0);
    chk_w("rst_burst_o", LW'(burst_o), '0);
    @(negedge clk);
    read_i  = 1'b0;
    write_i = 1'b0;
    resp_i  = 1'b0;
    reset_n = 1'b1;
  endtask

  // One line transaction with random memory stalls. abort_at > 0 fires a
  // reset on that cycle instead of completing. rl returns the read line.
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [LW-1:0] wl, input int stall_pct,
                         input int abort_at, output logic [LW-1:0] rl);
    int  k;
    int  cyc;
    bit  done;
    @(negedge clk);
    read_i = rd; write_i = wr; address_i = a; line_i = wl; resp_i = 1'b0;
    k = 0; cyc = 0; done = 0; rl = '0;
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (cyc == abort_at) begin
        read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
        do_reset();
        return;
      end
      if (resp_o) begin
        done = 1;
        read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
        if (rd) chk_w("txn_line", line_o, rl);
      end else if (cyc > 300) begin
        checks++; errors++;
        $display("FAIL txn_timeout: got no resp_o expected resp_o within 300 cycles");
        done = 1;
        read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
      end else begin
        resp_i  = ($urandom_range(99) >= stall_pct);
        burst_i = {$urandom, $urandom};
        if (read_o && resp_i && k < NB) begin
          rl[k*BW +: BW] = burst_i;
          k++;
        end
      end
    end
  endtask

  logic [BW-1:0] obs [9];
  logic [LW-1:0] r1, r2, dummy;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BW-1:0] beats [NB];
    logic [BW-1:0] wexp [8];
    bit   [8:0]    pat;
    int            lat;
    int            acc;

    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Reset then idle: strobes with no request must do nothing.
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      resp_i = i[0];
      burst_i = {$urandom, $urandom};
      chk_b("idle_resp_o", resp_o, 1'b0);
    end
    resp_i = 1'b0;

    // Back-to-back read, no stalls.
    beats[0] = 64'h1111_1111_1111_1111;
    beats[1] = 64'h2222_2222_2222_2222;
    beats[2] = 64'h3333_3333_3333_3333;
    beats[3] = 64'h4444_4444_4444_4444;
    @(negedge clk);
    read_i = 1'b1; address_i = 32'h0000_104C;
    lat = 0;
    for (int i = 0; i < NB; i++) begin
      @(negedge clk);
      lat++;
      resp_i = 1'b1; burst_i = beats[i];
    end
    @(negedge clk);
    lat++;
    resp_i = 1'b0; read_i = 1'b0;
    chk_b("rd_resp_at_6", resp_o, 1'b1);
    chk_w("rd_latency", LW'(lat), LW'(5));
    chk_w("rd_addr", LW'(address_o), LW'(32'h0000_1040));
    chk_w("rd_line", line_o,
          256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);
    @(negedge clk);
    chk_b("rd_resp_single", resp_o, 1'b0);

    // Stalled write: strobe pattern 0,0,0,1,0,1,1,0,1.
    pat = 9'b101101000;
    wexp = '{64'hA0A0_A0A0_A0A0_A0A0, 64'hA0A0_A0A0_A0A0_A0A0,
             64'hA0A0_A0A0_A0A0_A0A0, 64'hA0A0_A0A0_A0A0_A0A0,
             64'hA1A1_A1A1_A1A1_A1A1, 64'hA1A1_A1A1_A1A1_A1A1,
             64'hA2A2_A2A2_A2A2_A2A2, 64'hA3A3_A3A3_A3A3_A3A3};
    @(negedge clk);
    write_i = 1'b1; address_i = 32'h0000_2000;
    line_i = {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2,
              64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0};
    acc = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      obs[i] = burst_o;
      resp_i = pat[i];
      if (write_o && resp_i) acc++;
    end
    @(negedge clk);
    resp_i = 1'b0; write_i = 1'b0;
    chk_b("wr_resp", resp_o, 1'b1);
    chk_w("wr_beats_accepted", LW'(acc), LW'(4));
    for (int i = 0; i < 8; i++) chk_w($sformatf("wr_beat_seq%0d", i), LW'(obs[i]), LW'(wexp[i]));
    @(negedge clk);
    chk_b("wr_resp_single", resp_o, 1'b0);

    // Simultaneous read and write: read wins, held write starts afterwards.
    @(negedge clk);
    read_i = 1'b1; write_i = 1'b1; address_i = 32'h0000_3010;
    line_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < NB; i++) begin
      @(negedge clk);
      chk_b("both_write_o_low", write_o, 1'b0);
      resp_i = 1'b1; burst_i = {$urandom, $urandom};
    end
    @(negedge clk);
    resp_i = 1'b0; read_i = 1'b0;
    chk_b("both_resp", resp_o, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk_b("held_write_starts", write_o, 1'b1);
    write_i = 1'b0;
    for (int i = 0; i < NB; i++) begin
      resp_i = 1'b1;
      @(negedge clk);
    end
    resp_i = 1'b0;
    chk_b("held_write_resp", resp_o, 1'b1);

    // Reset mid-read after two beats, then a clean read.
    run_txn(1'b1, 1'b0, 32'h0000_4000, '0, 0, 3, dummy);
    run_txn(1'b1, 1'b0, 32'h0000_4020, '0, 30, 0, r1);

    // Read, write, read: line_o follows reads only.
    run_txn(1'b0, 1'b1, 32'h0000_5000, {8{$urandom}}, 30, 0, dummy);
    @(negedge clk);
    chk_w("rwr_hold", line_o, r1);
    run_txn(1'b1, 1'b0, 32'h0000_6000, '0, 30, 0, r2);
    chk_w("rwr_second", line_o, r2);

    // Randomized traffic with occasional aborting resets.
    for (int n = 0; n < 300; n++) begin
      bit rd, wr;
      int ab;
      rd = $urandom_range(1);
      wr = rd ? $urandom_range(1) : 1'b1;
      ab = ($urandom_range(19) == 0) ? $urandom_range(6, 1) : 0;
      run_txn(rd, wr, $urandom, {$urandom, $urandom, $urandom, $urandom,
                                 $urandom, $urandom, $urandom, $urandom},
              $urandom_range(60), ab, dummy);
      repeat ($urandom_range(2)) @(negedge clk);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
